// File: rtl/stack_access_unit.sv
// MEM-stage stack sequencer: owns SP and occupancy, and issues multi-word
// PUSH/POP transfers one word per cycle against a single-port data memory.
module stack_access_unit #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 12,
  parameter int MAX_BEATS = 2,
  parameter int DEPTH     = 2048,
  parameter int SP_RESET  = 2047
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_push,
  input  logic [$clog2(MAX_BEATS+1)-1:0]       req_beats,
  input  logic [MAX_BEATS*DATA_W-1:0]          req_data,
  output logic                                 rsp_valid,
  output logic [MAX_BEATS*DATA_W-1:0]          rsp_data,
  output logic                                 stall_out,
  output logic                                 exc_overflow,
  output logic                                 exc_underflow,
  output logic                                 exc_badlen,
  output logic [ADDR_W-1:0]                    SP_val_out,
  output logic [ADDR_W:0]                      count_out,
  output logic [ADDR_W-1:0]                    mem_addr,
  output logic [DATA_W-1:0]                    mem_wdata,
  output logic                                 mem_we,
  output logic                                 mem_re,
  input  logic [DATA_W-1:0]                    mem_rdata
);

  localparam int BW    = $clog2(MAX_BEATS + 1);
  localparam int PW    = MAX_BEATS * DATA_W;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   sp;
  logic [CNT_W-1:0]    count;
  logic                push_q;
  logic [BW-1:0]       beats_q;
  logic [BW-1:0]       k;
  logic [PW-1:0]       data_q;
  logic [PW-1:0]       hold;
  logic [PW-1:0]       hold_next;
  logic                last_beat;
  logic                is_badlen;
  logic                is_ovf;
  logic                is_udf;

  // Places one popped word into a payload; first-popped word lands in the top used slice.
  function automatic logic [PW-1:0] put_slice(input logic [PW-1:0] v, input int idx,
                                              input logic [DATA_W-1:0] w);
    logic [PW-1:0] r;
    r = v;
    r[idx*DATA_W +: DATA_W] = w;
    return r;
  endfunction

  assign last_beat  = (k == beats_q - BW'(1));
  assign is_badlen  = int'(req_beats) > MAX_BEATS;
  assign is_ovf     = req_push && (int'(count) + int'(req_beats) > DEPTH);
  assign is_udf     = !req_push && (int'(req_beats) > int'(count));

  always_comb begin
    hold_next = put_slice(hold, int'(beats_q) - 1 - int'(k), mem_rdata);
  end

  assign req_ready  = (state == IDLE);
  assign stall_out  = (state == XFER) || (state == DONE);
  assign mem_we     = (state == XFER) && push_q;
  assign mem_re     = (state == XFER) && !push_q;
  assign mem_addr   = push_q ? sp : sp + ADDR_W'(1);
  assign mem_wdata  = data_q[int'(k)*DATA_W +: DATA_W];
  assign SP_val_out = sp;
  assign count_out  = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      sp            <= ADDR_W'(SP_RESET);
      count         <= '0;
      k             <= '0;
      rsp_data      <= '0;
      rsp_valid     <= 1'b0;
      exc_overflow  <= 1'b0;
      exc_underflow <= 1'b0;
      exc_badlen    <= 1'b0;
    end else begin
      rsp_valid     <= 1'b0;
      exc_overflow  <= 1'b0;
      exc_underflow <= 1'b0;
      exc_badlen    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            push_q  <= req_push;
            beats_q <= req_beats;
            data_q  <= req_data;
            hold    <= '0;
            k       <= '0;
            if (is_badlen)
              exc_badlen <= 1'b1;
            else if (is_ovf)
              exc_overflow <= 1'b1;
            else if (is_udf)
              exc_underflow <= 1'b1;
            else if (req_beats == '0) begin
              // Zero-length pop completes with an all-empty payload.
              state     <= DONE;
              rsp_valid <= 1'b1;
              if (!req_push)
                rsp_data <= '0;
            end else
              state <= XFER;
          end
        end
        XFER: begin
          sp <= push_q ? sp - ADDR_W'(1) : sp + ADDR_W'(1);
          if (!push_q)
            hold <= hold_next;
          if (last_beat) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            count     <= push_q ? count + CNT_W'(beats_q) : count - CNT_W'(beats_q);
            if (!push_q)
              rsp_data <= hold_next;
          end else
            k <= k + BW'(1);
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
